// File: rtl/priority_serializer.sv
// Sticky 16-bit request collector feeding an external priority encoder;
// serves one encoded index per valid/ready transfer, highest index first.
module priority_serializer #(
  parameter logic [7:0] NONE_CODE = 8'hF0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      req_in,
  output logic [7:0]       enc_a,
  output logic [7:0]       enc_b,
  input  logic [7:0]       enc_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_idx,
  output logic [15:0]      pending,
  output logic             overrun,
  output logic             code_err,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e           state_q;
  logic [15:0]      pending_q;
  logic [15:0]      pending_d;
  logic [15:0]      clr;
  logic             hs;
  logic             ovr_hit;
  logic             code_ok;
  logic             code_none;
  logic             out_valid_q;
  logic [3:0]       out_idx_q;
  logic             overrun_q;
  logic             code_err_q;
  logic [CNT_W-1:0] xfer_cnt_q;

  assign enc_a = pending_q[15:8];
  assign enc_b = pending_q[7:0];

  assign hs  = out_valid_q & out_ready;
  assign clr = hs ? (16'd1 << out_idx_q) : 16'd0;

  // A same-cycle request re-arms a bit being cleared rather than losing it.
  assign pending_d = (pending_q & ~clr) | req_in;
  assign ovr_hit   = |(req_in & pending_q & ~clr);

  assign code_ok   = (enc_c <= 8'd15);
  assign code_none = (enc_c == NONE_CODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (ovr_hit)
        overrun_q <= 1'b1;
    end
  end

  // Returning to IDLE after each transfer lets the encoder see the
  // cleared vector before the next index is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      code_err_q  <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (code_ok) begin
            out_idx_q   <= enc_c[3:0];
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else if (!code_none) begin
            code_err_q  <= 1'b1;
          end
        end
        HOLD: begin
          if (hs) begin
            xfer_cnt_q  <= xfer_cnt_q + CNT_W'(1);
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;
  assign code_err  = code_err_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_priority_serializer.sv
// Bench for priority_serializer: behavioural encoder, cycle model,
// and a queue of expected served indices checked on each handshake.
module tb_priority_serializer;

  logic        clk;
  logic        rst_n;
  logic [15:0] req_in;
  logic [7:0]  enc_a;
  logic [7:0]  enc_b;
  logic [7:0]  enc_c;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic [15:0] pending;
  logic        overrun;
  logic        code_err;
  logic [7:0]  xfer_cnt;

  logic        force_en;
  logic [7:0]  force_val;

  int n_checks;
  int n_pass;

  logic [3:0]  exp_q[$];

  logic [15:0] m_pend;
  logic        m_busy;
  logic [3:0]  m_idx;
  logic        m_ovr;
  logic        m_err;
  logic [7:0]  m_cnt;

  priority_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .enc_c     (enc_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending),
    .overrun   (overrun),
    .code_err  (code_err),
    .xfer_cnt  (xfer_cnt)
  );

  function automatic logic [7:0] top_bit(input logic [15:0] v);
    for (int i = 15; i >= 0; i--)
      if (v[i]) return 8'(i);
    return 8'hF0;
  endfunction

  assign enc_c = force_en ? force_val : top_bit({enc_a, enc_b});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 32'(out_idx), 32'hFFFF);
      end else begin
        chk("sb_idx", 32'(out_idx), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic model_reset();
    m_pend = '0; m_busy = 0; m_idx = '0;
    m_ovr = 0; m_err = 0; m_cnt = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [15:0] old_p;
    logic [15:0] clr;
    logic [7:0]  code;
    logic        hs;
    old_p = m_pend;
    code  = force_en ? force_val : top_bit(old_p);
    hs    = m_busy && out_ready;
    clr   = '0;
    if (hs) clr[m_idx] = 1'b1;
    if ((req_in & old_p & ~clr) != 0) m_ovr = 1;
    m_pend = (old_p & ~clr) | req_in;
    if (hs) begin
      m_busy = 0;
      m_cnt  = m_cnt + 8'd1;
    end else if (!m_busy) begin
      if (code <= 8'd15) begin
        m_idx  = code[3:0];
        m_busy = 1;
        exp_q.push_back(m_idx);
      end else if (code != 8'hF0) begin
        m_err = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("valid",    32'(out_valid), 32'(m_busy));
    chk("idx",      32'(out_idx),   32'(m_idx));
    chk("pending",  32'(pending),   32'(m_pend));
    chk("enc_ab",   32'({enc_a, enc_b}), 32'(m_pend));
    chk("overrun",  32'(overrun),   32'(m_ovr));
    chk("code_err", 32'(code_err),  32'(m_err));
    chk("xfer_cnt", 32'(xfer_cnt),  32'(m_cnt));
  endtask

  task automatic cycle(input logic [15:0] r, input logic rdy);
    req_in = r;
    out_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 0;
    req_in = 16'hFFFF;
    out_ready = 1;
    force_en = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_zero", 32'({out_valid, out_idx, pending, overrun, code_err, xfer_cnt}), 32'h0);
    chk("rst_enc", 32'({enc_a, enc_b}), 32'h0);
    rst_n = 1;
    req_in = 0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 0; req_in = 0; out_ready = 0;
    force_en = 0; force_val = 8'hF0;
    model_reset();

    do_reset();
    repeat (5) cycle(16'h0, 1'b1);
    chk("idle_valid", 32'(out_valid), 32'h0);

    do_reset();
    cycle(16'h0020, 1'b1);
    cycle(16'h0, 1'b1);
    chk("single_idx", 32'({out_valid, out_idx}), 32'h15);
    cycle(16'h0, 1'b1);
    chk("single_done", 32'({out_valid, pending, xfer_cnt}), 32'h0_0000_01);

    do_reset();
    cycle(16'h8101, 1'b1);
    repeat (7) cycle(16'h0, 1'b1);
    chk("drain_cnt", 32'(xfer_cnt), 32'd3);

    do_reset();
    cycle(16'h0004, 1'b0);
    cycle(16'h0, 1'b0);
    cycle(16'h4000, 1'b0);
    repeat (3) cycle(16'h0, 1'b0);
    chk("bp_idx", 32'({out_valid, out_idx}), 32'h12);
    cycle(16'h0, 1'b1);
    cycle(16'h0, 1'b1);
    chk("bp_next", 32'({out_valid, out_idx}), 32'h1E);
    cycle(16'h0, 1'b1);

    do_reset();
    cycle(16'h0008, 1'b0);
    cycle(16'h0, 1'b0);
    cycle(16'h0008, 1'b0);
    chk("ovr_set", 32'(overrun), 32'h1);

    do_reset();
    cycle(16'h0008, 1'b1);
    cycle(16'h0, 1'b1);
    cycle(16'h0008, 1'b1);
    chk("rereq_ovr", 32'({overrun, pending}), 32'h0_0008);
    repeat (3) cycle(16'h0, 1'b1);
    chk("rereq_cnt", 32'(xfer_cnt), 32'd2);

    do_reset();
    force_en = 1; force_val = 8'h20;
    cycle(16'h0080, 1'b0);
    cycle(16'h0, 1'b0);
    chk("bad_code", 32'({code_err, out_valid}), 32'h2);
    force_en = 0;
    cycle(16'h0, 1'b0);
    chk("code_restore", 32'({out_valid, out_idx}), 32'h17);
    cycle(16'h0, 1'b1);

    do_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        logic [15:0] r;
        r = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0;
        if ($urandom_range(0, 49) == 0) begin
          force_en = 1;
          force_val = 8'($urandom);
        end else begin
          force_en = 0;
        end
        cycle(r, 1'($urandom_range(0, 1)));
      end
    end
    force_en = 0;

    do_reset();
    repeat (600) cycle(16'hFFFF, 1'b1);
    repeat (40) cycle(16'h0, 1'b1);
    chk("final_empty", 32'({out_valid, pending}), 32'h0);
    chk("sb_left", 32'(exp_q.size()), 32'(m_busy));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
